// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: slot record and forwarding-select encoding shared by the controller and its comparators.
package pipeline_ctrl_pkg;
  localparam int SLOT_AW = 8;
  localparam int FWD_W = 4;
  localparam logic [FWD_W-1:0] FWD_GPR = '0;
  typedef struct packed {
    logic valid;
    logic [SLOT_AW-1:0] rd;
    logic we;
    logic late;
  } slot_t;
endpackage

// File: rtl/pipeline_ctrl_hazard_cmp.sv
// hazard_cmp: one source operand against every in-flight slot; youngest match wins.
module hazard_cmp
  import pipeline_ctrl_pkg::*;
#(
  parameter int NUM_ENTRIES = 4,
  parameter int ADDR_WIDTH = 5,
  parameter int FAST_READY = 1,
  parameter int LATE_READY = 3
) (
  input  slot_t [NUM_ENTRIES-1:0] slots,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic                    used,
  output logic                    hit,
  output logic [FWD_W-1:0]        sel,
  output logic                    not_ready
);
  logic [FWD_W-1:0] idx;
  logic late, ready;
  always_comb begin
    hit = 1'b0;
    idx = '0;
    late = 1'b0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--)
      if (used && addr != '0 && slots[i].valid && slots[i].we && slots[i].rd == SLOT_AW'(addr)) begin
        hit = 1'b1;
        idx = FWD_W'(i);
        late = slots[i].late;
      end
    ready = int'(idx) >= (late ? LATE_READY : FAST_READY);
    sel = hit && ready ? idx + 1'b1 : FWD_GPR;
    not_ready = hit && !ready;
  end
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: in-flight slot tracker with forwarding select, load-use stall and flush.
// Optional performance counters enabled by PIPELINE_CTRL_PERF_EN.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int NUM_ENTRIES = 4,
  parameter int ADDR_WIDTH = 5,
  parameter int FAST_READY = 1,
  parameter int LATE_READY = 3,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic                   clock_in,
  input  logic                   reset_in,
  input  logic                   id_valid_in,
  input  logic [ADDR_WIDTH-1:0]  id_rs1_addr_in,
  input  logic [ADDR_WIDTH-1:0]  id_rs2_addr_in,
  input  logic                   id_rs1_used_in,
  input  logic                   id_rs2_used_in,
  input  logic [ADDR_WIDTH-1:0]  id_rd_addr_in,
  input  logic                   id_rd_we_in,
  input  logic                   id_late_in,
  input  logic                   flush_in,
  output logic                   stall_out,
  output logic [NUM_ENTRIES-1:0] slot_valid_out,
  output logic [FWD_W-1:0]       fwd_a_sel_out,
  output logic [FWD_W-1:0]       fwd_b_sel_out,
  output logic [31:0]            stall_count_out,
  output logic [31:0]            flush_count_out
);
  slot_t [NUM_ENTRIES-1:0] slots, nxt;
  logic a_hit, b_hit, a_nr, b_nr;
  hazard_cmp #(.NUM_ENTRIES(NUM_ENTRIES), .ADDR_WIDTH(ADDR_WIDTH), .FAST_READY(FAST_READY), .LATE_READY(LATE_READY)) u_cmp_a (
    .slots(slots), .addr(id_rs1_addr_in), .used(id_rs1_used_in), .hit(a_hit), .sel(fwd_a_sel_out), .not_ready(a_nr)
  );
  hazard_cmp #(.NUM_ENTRIES(NUM_ENTRIES), .ADDR_WIDTH(ADDR_WIDTH), .FAST_READY(FAST_READY), .LATE_READY(LATE_READY)) u_cmp_b (
    .slots(slots), .addr(id_rs2_addr_in), .used(id_rs2_used_in), .hit(b_hit), .sel(fwd_b_sel_out), .not_ready(b_nr)
  );
  assign stall_out = id_valid_in && !flush_in && (a_nr || b_nr);
  always_comb begin
    nxt[0] = '0;
    if (!(flush_in || stall_out)) begin
      nxt[0].valid = id_valid_in;
      nxt[0].rd = SLOT_AW'(id_rd_addr_in);
      nxt[0].we = id_rd_we_in;
      nxt[0].late = id_late_in;
    end
    for (int i = 1; i < NUM_ENTRIES; i++) begin
      nxt[i] = slots[i-1];
      if (flush_in && i < FLUSH_DEPTH) nxt[i].valid = 1'b0;
    end
  end
  always_ff @(posedge clock_in or posedge reset_in)
    if (reset_in) slots <= '0;
    else slots <= nxt;
  for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_valid
    assign slot_valid_out[g] = slots[g].valid;
  end
`ifdef PIPELINE_CTRL_PERF_EN
  always_ff @(posedge clock_in or posedge reset_in)
    if (reset_in) begin
      stall_count_out <= '0;
      flush_count_out <= '0;
    end else begin
      if (stall_out && stall_count_out != '1) stall_count_out <= stall_count_out + 1'b1;
      if (flush_in && flush_count_out != '1) flush_count_out <= flush_count_out + 1'b1;
    end
`else
  assign stall_count_out = '0;
  assign flush_count_out = '0;
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed checks of forwarding, stall, flush, retire and async reset.
module tb_pipeline_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic id_valid, rs1_used, rs2_used, rd_we, late, flush;
  logic [4:0] rs1, rs2, rd;
  logic stall;
  logic [3:0] slot_valid, fwd_a, fwd_b;
  logic [31:0] stall_cnt, flush_cnt;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  pipeline_ctrl dut (
    .clock_in(clk), .reset_in(rst), .id_valid_in(id_valid),
    .id_rs1_addr_in(rs1), .id_rs2_addr_in(rs2), .id_rs1_used_in(rs1_used), .id_rs2_used_in(rs2_used),
    .id_rd_addr_in(rd), .id_rd_we_in(rd_we), .id_late_in(late), .flush_in(flush),
    .stall_out(stall), .slot_valid_out(slot_valid), .fwd_a_sel_out(fwd_a), .fwd_b_sel_out(fwd_b),
    .stall_count_out(stall_cnt), .flush_count_out(flush_cnt)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic id(input logic v, input logic [4:0] a1, input logic u1, input logic [4:0] a2,
                    input logic u2, input logic [4:0] d, input logic w, input logic l);
    id_valid = v; rs1 = a1; rs1_used = u1; rs2 = a2; rs2_used = u2; rd = d; rd_we = w; late = l;
    #1;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drain();
    id(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) tick();
  endtask
  initial begin
    flush = 0;
    id(0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_stall", 32'(stall), 0);
    check("rst_valid", 32'(slot_valid), 0);
    check("rst_fwd_a", 32'(fwd_a), 0);
    check("rst_fwd_b", 32'(fwd_b), 0);
    check("rst_scnt", stall_cnt, 0);
    check("rst_fcnt", flush_cnt, 0);
    @(negedge clk);
    rst = 0;
    id(1, 0, 0, 0, 0, 5, 1, 0);
    tick();
    id(1, 5, 1, 0, 0, 0, 0, 0);
    check("fast_s0_stall", 32'(stall), 1);
    id(0, 5, 1, 0, 0, 0, 0, 0);
    check("novalid_stall", 32'(stall), 0);
    tick();
    id(1, 5, 1, 0, 0, 0, 0, 0);
    check("fast_s1_fwd_a", 32'(fwd_a), 2);
    check("fast_s1_stall", 32'(stall), 0);
    drain();
    id(1, 0, 0, 0, 0, 7, 1, 1);
    tick();
    id(1, 0, 0, 7, 1, 0, 0, 0);
    check("lu_s0_stall", 32'(stall), 1);
    tick();
    check("lu_s1_stall", 32'(stall), 1);
    check("lu_s1_valid", 32'(slot_valid), 4'b0010);
    tick();
    check("lu_s2_stall", 32'(stall), 1);
    tick();
    check("lu_s3_stall", 32'(stall), 0);
    check("lu_s3_fwd_b", 32'(fwd_b), 4);
    id(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check("retire_valid", 32'(slot_valid), 0);
    id(1, 0, 0, 0, 0, 3, 1, 0);
    tick();
    tick();
    id(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    id(1, 3, 1, 3, 0, 0, 0, 0);
    check("young_fwd_a", 32'(fwd_a), 2);
    check("unused_fwd_b", 32'(fwd_b), 0);
    check("young_stall", 32'(stall), 0);
    drain();
    id(1, 0, 0, 0, 0, 0, 1, 0);
    tick();
    id(1, 0, 1, 0, 1, 0, 0, 0);
    check("x0_fwd_a", 32'(fwd_a), 0);
    check("x0_fwd_b", 32'(fwd_b), 0);
    check("x0_stall", 32'(stall), 0);
    drain();
    id(1, 0, 0, 0, 0, 7, 1, 1);
    tick();
    id(1, 0, 0, 7, 1, 0, 0, 0);
    tick();
    check("fl_pre_stall", 32'(stall), 1);
    flush = 1;
    #1;
    check("fl_stall", 32'(stall), 0);
    tick();
    flush = 0;
    id(0, 0, 0, 0, 0, 0, 0, 0);
    check("fl_valid", 32'(slot_valid), 4'b0100);
`ifdef PIPELINE_CTRL_PERF_EN
    check("fl_fcnt", flush_cnt, 1);
`else
    check("fl_fcnt", flush_cnt, 0);
`endif
    id(1, 0, 0, 0, 0, 4, 1, 0);
    tick();
    check("fl2_pre_valid", 32'(slot_valid), 4'b1001);
    flush = 1;
    id(1, 0, 0, 0, 0, 6, 1, 0);
    tick();
    flush = 0;
    id(0, 0, 0, 0, 0, 0, 0, 0);
    check("fl2_valid", 32'(slot_valid), 0);
`ifdef PIPELINE_CTRL_PERF_EN
    check("perf_scnt", stall_cnt, 4);
    check("perf_fcnt", flush_cnt, 2);
`else
    check("perf_scnt", stall_cnt, 0);
    check("perf_fcnt", flush_cnt, 0);
`endif
    id(1, 0, 0, 0, 0, 7, 1, 1);
    tick();
    id(1, 0, 0, 7, 1, 0, 0, 0);
    check("ar_pre_stall", 32'(stall), 1);
    #1 rst = 1;
    #1;
    check("ar_stall", 32'(stall), 0);
    check("ar_valid", 32'(slot_valid), 0);
    check("ar_scnt", stall_cnt, 0);
    @(negedge clk);
    rst = 0;
    id(1, 0, 0, 0, 0, 9, 1, 0);
    tick();
    check("post_rst_valid", 32'(slot_valid), 4'b0001);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
